// File: rtl/fetch_pkg.sv
// ----------------------------------------------------------------------------
// fetch_pkg
// Shared definitions for the instruction fetch unit and its buffer.
//   RESET_PC_DEFAULT : default first fetch address after reset
//   PC_STEP          : byte distance between consecutive instructions
//   FETCH_DEPTH      : number of entries in the fetch buffer
//   COUNT_W          : width of the buffer occupancy counter (0..FETCH_DEPTH)
//   fetch_entry_t    : one buffered instruction with its address
//   fetch_mode_t     : per-cycle control decode of halt / flush / run
//   align_pc()       : clears the byte-offset bits of a redirect address
// ----------------------------------------------------------------------------
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] PC_STEP          = 32'd4;
    localparam int unsigned FETCH_DEPTH      = 2;
    localparam int unsigned COUNT_W          = $clog2(FETCH_DEPTH + 1);

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Priority order: halt beats flush beats normal running.
    typedef enum logic [1:0] {
        ModeRun,
        ModeFlush,
        ModeHalt
    } fetch_mode_t;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & ~32'd3;
    endfunction

endpackage

// File: rtl/fetch_fifo.sv
// ----------------------------------------------------------------------------
// fetch_fifo
// Two-entry instruction buffer between instruction memory and decode.
// Entry 0 is always the head; a pop shifts entry 1 down.
// Ports:
//   clk        : clock, state updates on posedge
//   rst        : asynchronous active-high reset, empties the buffer
//   flush      : synchronous clear, takes priority over push/pop
//   push       : write push_entry at the tail this edge
//   push_entry : {instr, pc} to write
//   pop        : consume the head this edge (ignored when empty)
//   count      : current occupancy, 0..FETCH_DEPTH
//   head       : head entry, all-zero when empty
// ----------------------------------------------------------------------------
module fetch_fifo
    import fetch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  fetch_entry_t       push_entry,
    input  logic               pop,
    output logic [COUNT_W-1:0] count,
    output fetch_entry_t       head
);

    fetch_entry_t       slot0_q, slot0_d;
    fetch_entry_t       slot1_q, slot1_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic               do_pop;
    logic               do_push;

    assign do_pop  = pop && (count_q != '0);
    // A push into a full buffer is only legal alongside a pop.
    assign do_push = push && ((count_q != COUNT_W'(FETCH_DEPTH)) || do_pop);

    always_comb begin
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        count_d = count_q;
        if (flush) begin
            slot0_d = '0;
            slot1_d = '0;
            count_d = '0;
        end else begin
            if (do_pop) begin
                slot0_d = slot1_q;
                slot1_d = '0;
            end
            if (do_push) begin
                // Write slot is the occupancy remaining after this edge's pop.
                if ((count_q - COUNT_W'(do_pop)) == '0) begin
                    slot0_d = push_entry;
                end else begin
                    slot1_d = push_entry;
                end
            end
            count_d = count_q + COUNT_W'(do_push) - COUNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot0_q <= '0;
            slot1_q <= '0;
            count_q <= '0;
        end else begin
            slot0_q <= slot0_d;
            slot1_q <= slot1_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = (count_q == '0) ? '0 : slot0_q;

endmodule

// File: rtl/fetch.sv
// ----------------------------------------------------------------------------
// fetch
// Instruction fetch unit: issues sequential reads to a one-cycle-latency
// instruction memory, buffers returned instructions in a two-entry FIFO and
// presents the head to decode. Supports stall, redirect (flush) and halt.
// Ports:
//   clk        : clock, state updates on posedge
//   rst        : asynchronous active-high reset
//   halt       : freeze all state; dominates every other input
//   stall      : decode cannot accept the head this cycle
//   flush      : redirect to branch_tgt, discarding buffered/in-flight fetches
//   branch_tgt : redirect address, sampled while flush=1
//   imem_re    : memory read request (combinational)
//   imem_addr  : memory read address, equals the fetch PC register
//   imem_data  : memory read data, valid the cycle after a request
//   instr_out  : instruction at the buffer head
//   pc_out     : address of instr_out
//   bubble_out : 1 when instr_out/pc_out carry no valid instruction
// ----------------------------------------------------------------------------
module fetch
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        halt,
    input  logic        stall,
    input  logic        flush,
    input  logic [31:0] branch_tgt,
    output logic        imem_re,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        bubble_out
);

    fetch_mode_t        mode;
    logic [31:0]        fpc_q;
    logic               infl_q;
    logic [31:0]        infl_pc_q;
    logic [COUNT_W-1:0] count;
    logic [COUNT_W:0]   occupancy;
    fetch_entry_t       head;
    fetch_entry_t       push_entry;
    logic               pop;
    logic               push;
    logic               issue;

    always_comb begin
        if (halt) begin
            mode = ModeHalt;
        end else if (flush) begin
            mode = ModeFlush;
        end else begin
            mode = ModeRun;
        end
    end

    // Buffered plus in-flight instructions; a new request is only made when
    // its data is guaranteed a free slot on return.
    assign occupancy = {1'b0, count} + {{COUNT_W{1'b0}}, infl_q};
    assign pop       = (mode == ModeRun) && !stall && (count != '0);
    assign issue     = !rst && (mode == ModeRun)
                       && ((occupancy < (COUNT_W + 1)'(FETCH_DEPTH)) || pop);

    // Returning data is captured only while running; flush and halt drop it.
    assign push       = (mode == ModeRun) && infl_q;
    assign push_entry = '{instr: imem_data, pc: infl_pc_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fpc_q     <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
        end else begin
            unique case (mode)
                ModeHalt: begin
                    // The response arriving now is discarded, so rewind to
                    // refetch it once the halt is released.
                    if (infl_q) begin
                        infl_q <= 1'b0;
                        fpc_q  <= infl_pc_q;
                    end
                end
                ModeFlush: begin
                    infl_q <= 1'b0;
                    fpc_q  <= align_pc(branch_tgt);
                end
                default: begin
                    infl_q <= issue;
                    if (issue) begin
                        infl_pc_q <= fpc_q;
                        fpc_q     <= fpc_q + PC_STEP;
                    end
                end
            endcase
        end
    end

    fetch_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .flush      (mode == ModeFlush),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (count),
        .head       (head)
    );

    assign imem_re    = issue;
    assign imem_addr  = fpc_q;
    assign bubble_out = (count == '0) || (mode == ModeFlush);
    assign instr_out  = head.instr;
    assign pc_out     = head.pc;

endmodule

// File: tb/tb_fetch.sv
// ----------------------------------------------------------------------------
// tb_fetch
// Directed bench for the fetch unit. Two instances share clk/rst: dut with the
// default reset PC (driven by the scenario tasks) and dut_hi with reset PC
// FFFF_FFF8 running free to show address wrap. Each memory model returns
// addr ^ DATA_KEY one cycle after a request so instr and pc are distinct.
// ----------------------------------------------------------------------------
module tb_fetch;

    localparam logic [31:0] DATA_KEY = 32'h5A00_0000;
    localparam logic [31:0] HI_RESET = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        stall;
    logic        flush;
    logic [31:0] branch_tgt;
    logic        imem_re;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        bubble_out;

    logic        hi_re;
    logic [31:0] hi_addr;
    logic [31:0] hi_data;
    logic [31:0] hi_instr;
    logic [31:0] hi_pc;
    logic        hi_bubble;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        imem_data <= imem_re ? (imem_addr ^ DATA_KEY) : 32'hDEAD_BEEF;
        hi_data   <= hi_re ? (hi_addr ^ DATA_KEY) : 32'hDEAD_BEEF;
    end

    fetch dut (
        .clk        (clk),
        .rst        (rst),
        .halt       (halt),
        .stall      (stall),
        .flush      (flush),
        .branch_tgt (branch_tgt),
        .imem_re    (imem_re),
        .imem_addr  (imem_addr),
        .imem_data  (imem_data),
        .instr_out  (instr_out),
        .pc_out     (pc_out),
        .bubble_out (bubble_out)
    );

    fetch #(
        .RESET_PC (HI_RESET)
    ) dut_hi (
        .clk        (clk),
        .rst        (rst),
        .halt       (1'b0),
        .stall      (1'b0),
        .flush      (1'b0),
        .branch_tgt (32'h0),
        .imem_re    (hi_re),
        .imem_addr  (hi_addr),
        .imem_data  (hi_data),
        .instr_out  (hi_instr),
        .pc_out     (hi_pc),
        .bubble_out (hi_bubble)
    );

    // Advance to just after the next rising edge (input drive point).
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at cycle 0: reset just released, post-edge drive point.
    task automatic apply_reset();
        rst        = 1'b1;
        halt       = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        branch_tgt = 32'h0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst        = 1'b1;
        halt       = 1'b0;
        stall      = 1'b0;
        flush      = 1'b0;
        branch_tgt = 32'h0;
        repeat (2) @(negedge clk);
        vectors++;
        if (imem_re !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_re: got %b want 0", imem_re);
        end
        vectors++;
        if (bubble_out !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_bubble: got %b want 1", bubble_out);
        end
        vectors++;
        if (instr_out !== 32'h0 || pc_out !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_outs: got instr %h pc %h want 0 0", instr_out, pc_out);
        end
        vectors++;
        if (imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_addr: got %h want 00000000", imem_addr);
        end
        vectors++;
        if (hi_addr !== HI_RESET || hi_re !== 1'b0 || hi_bubble !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_hi: got addr %h re %b bubble %b want fffffff8 0 1",
                     hi_addr, hi_re, hi_bubble);
        end
    endtask

    // Free-running fetch on both instances, including the wrap past 2^32.
    task automatic test_stream();
        logic [31:0] e_addr;
        logic [31:0] e_pc;
        logic [31:0] e_hi;
        apply_reset();
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            e_addr = 32'(4 * c);
            vectors++;
            if (imem_addr !== e_addr || imem_re !== 1'b1) begin
                miscompares++;
                $display("FAIL stream_req c%0d: got addr %h re %b want %h 1",
                         c, imem_addr, imem_re, e_addr);
            end
            vectors++;
            if (bubble_out !== (c < 2)) begin
                miscompares++;
                $display("FAIL stream_bubble c%0d: got %b want %b", c, bubble_out, (c < 2));
            end
            if (c >= 2) begin
                e_pc = 32'(4 * (c - 2));
                e_hi = HI_RESET + 32'(4 * (c - 2));
                vectors++;
                if (pc_out !== e_pc || instr_out !== (e_pc ^ DATA_KEY)) begin
                    miscompares++;
                    $display("FAIL stream_out c%0d: got pc %h instr %h want %h %h",
                             c, pc_out, instr_out, e_pc, e_pc ^ DATA_KEY);
                end
                vectors++;
                if (hi_pc !== e_hi || hi_instr !== (e_hi ^ DATA_KEY) || hi_bubble !== 1'b0) begin
                    miscompares++;
                    $display("FAIL stream_wrap c%0d: got pc %h instr %h bubble %b want %h %h 0",
                             c, hi_pc, hi_instr, hi_bubble, e_hi, e_hi ^ DATA_KEY);
                end
            end
            next_cycle();
        end
    endtask

    // Stall 5 cycles with pc 8 at the head, then resume.
    task automatic test_stall();
        logic [31:0] resume_pc [4];
        resume_pc[0] = 32'd8;
        resume_pc[1] = 32'd12;
        resume_pc[2] = 32'd16;
        resume_pc[3] = 32'd20;
        apply_reset();
        repeat (4) next_cycle();
        stall = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            vectors++;
            if (pc_out !== 32'd8 || bubble_out !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold k%0d: got pc %h bubble %b want 00000008 0",
                         k, pc_out, bubble_out);
            end
            vectors++;
            if (imem_re !== 1'b0 || imem_addr !== 32'd16) begin
                miscompares++;
                $display("FAIL stall_req k%0d: got re %b addr %h want 0 00000010",
                         k, imem_re, imem_addr);
            end
            next_cycle();
        end
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            vectors++;
            if (pc_out !== resume_pc[k] || bubble_out !== 1'b0
                || instr_out !== (resume_pc[k] ^ DATA_KEY)) begin
                miscompares++;
                $display("FAIL stall_resume k%0d: got pc %h bubble %b instr %h want %h 0",
                         k, pc_out, bubble_out, instr_out, resume_pc[k]);
            end
            next_cycle();
        end
    endtask

    // Flush with a full buffer (and stall asserted), then flush again with
    // data in flight.
    task automatic test_flush();
        apply_reset();
        next_cycle();
        stall = 1'b1;
        next_cycle();
        next_cycle();
        // Cycle 3: two entries buffered, nothing in flight.
        @(negedge clk);
        vectors++;
        if (pc_out !== 32'h0 || imem_re !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_fill: got pc %h re %b want 00000000 0", pc_out, imem_re);
        end
        next_cycle();
        flush      = 1'b1;
        branch_tgt = 32'h0000_0103;
        @(negedge clk);
        vectors++;
        if (bubble_out !== 1'b1 || imem_re !== 1'b0) begin
            miscompares++;
            $display("FAIL flush_cycle: got bubble %b re %b want 1 0", bubble_out, imem_re);
        end
        next_cycle();
        flush = 1'b0;
        stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 2) begin
                vectors++;
                if (imem_addr !== 32'h100 + 32'(4 * k) || imem_re !== 1'b1
                    || bubble_out !== 1'b1) begin
                    miscompares++;
                    $display("FAIL flush_refetch k%0d: got addr %h re %b bubble %b want %h 1 1",
                             k, imem_addr, imem_re, bubble_out, 32'h100 + 32'(4 * k));
                end
            end else begin
                vectors++;
                if (pc_out !== 32'h100 + 32'(4 * (k - 2)) || bubble_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL flush_target k%0d: got pc %h bubble %b want %h 0",
                             k, pc_out, bubble_out, 32'h100 + 32'(4 * (k - 2)));
                end
            end
            next_cycle();
        end
        // Head 0x108, 0x10C in flight.
        flush      = 1'b1;
        branch_tgt = 32'h0000_0200;
        @(negedge clk);
        vectors++;
        if (pc_out !== 32'h108 || bubble_out !== 1'b1 || imem_re !== 1'b0) begin
            miscompares++;
            $display("FAIL flush2_cycle: got pc %h bubble %b re %b want 00000108 1 0",
                     pc_out, bubble_out, imem_re);
        end
        next_cycle();
        flush = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (k < 2) begin
                vectors++;
                if (bubble_out !== 1'b1 || pc_out !== 32'h0
                    || imem_addr !== 32'h200 + 32'(4 * k)) begin
                    miscompares++;
                    $display("FAIL flush2_drop k%0d: got bubble %b pc %h addr %h want 1 0 %h",
                             k, bubble_out, pc_out, imem_addr, 32'h200 + 32'(4 * k));
                end
            end else begin
                vectors++;
                if (pc_out !== 32'h200 + 32'(4 * (k - 2)) || bubble_out !== 1'b0) begin
                    miscompares++;
                    $display("FAIL flush2_target k%0d: got pc %h bubble %b want %h 0",
                             k, pc_out, bubble_out, 32'h200 + 32'(4 * (k - 2)));
                end
            end
            next_cycle();
        end
    endtask

    // Halt three cycles while the fetch of pc 20 is in flight.
    task automatic test_halt();
        apply_reset();
        repeat (6) next_cycle();
        halt = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            vectors++;
            if (pc_out !== 32'd16 || instr_out !== (32'd16 ^ DATA_KEY)
                || bubble_out !== 1'b0 || imem_re !== 1'b0) begin
                miscompares++;
                $display("FAIL halt_hold k%0d: got pc %h instr %h bubble %b re %b want 10 0 0",
                         k, pc_out, instr_out, bubble_out, imem_re);
            end
            vectors++;
            if (imem_addr !== ((k == 0) ? 32'd24 : 32'd20)) begin
                miscompares++;
                $display("FAIL halt_rewind k%0d: got addr %h want %h",
                         k, imem_addr, (k == 0) ? 32'd24 : 32'd20);
            end
            next_cycle();
        end
        halt = 1'b0;
        @(negedge clk);
        vectors++;
        if (imem_re !== 1'b1 || imem_addr !== 32'd20 || pc_out !== 32'd16) begin
            miscompares++;
            $display("FAIL halt_refetch: got re %b addr %h pc %h want 1 00000014 00000010",
                     imem_re, imem_addr, pc_out);
        end
        next_cycle();
        @(negedge clk);
        vectors++;
        if (bubble_out !== 1'b1) begin
            miscompares++;
            $display("FAIL halt_gap: got bubble %b want 1", bubble_out);
        end
        next_cycle();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            vectors++;
            if (pc_out !== 32'd20 + 32'(4 * k) || bubble_out !== 1'b0
                || instr_out !== ((32'd20 + 32'(4 * k)) ^ DATA_KEY)) begin
                miscompares++;
                $display("FAIL halt_resume k%0d: got pc %h bubble %b instr %h want %h 0",
                         k, pc_out, bubble_out, instr_out, 32'd20 + 32'(4 * k));
            end
            next_cycle();
        end
    endtask

    // Reset pulsed between clock edges mid-stream.
    task automatic test_async_reset();
        apply_reset();
        repeat (5) next_cycle();
        #1;
        vectors++;
        if (pc_out !== 32'd12 || bubble_out !== 1'b0) begin
            miscompares++;
            $display("FAIL areset_before: got pc %h bubble %b want 0000000c 0",
                     pc_out, bubble_out);
        end
        rst = 1'b1;
        #1;
        vectors++;
        if (bubble_out !== 1'b1 || imem_re !== 1'b0 || pc_out !== 32'h0
            || imem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL areset_now: got bubble %b re %b pc %h addr %h want 1 0 0 0",
                     bubble_out, imem_re, pc_out, imem_addr);
        end
        next_cycle();
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (imem_addr !== 32'(4 * c) || imem_re !== 1'b1 || bubble_out !== (c < 2)) begin
                miscompares++;
                $display("FAIL areset_restart c%0d: got addr %h re %b bubble %b want %h 1 %b",
                         c, imem_addr, imem_re, bubble_out, 32'(4 * c), (c < 2));
            end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_flush();
        test_halt();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
